// File: rtl/ft245_pkg.sv
// Shared types and default timing for the FT245 receive engine.
package ft245_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    RECOVER = 2'd2
  } state_e;

  localparam int unsigned DATA_W             = 8;
  localparam int unsigned RD_LOW_CYCLES_DEF  = 4;
  localparam int unsigned RD_HIGH_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF          = 16;

  // Timer must hold the larger of the two reload values (cycles - 1).
  function automatic int unsigned timer_width(input int unsigned low_cyc,
                                              input int unsigned high_cyc);
    int unsigned max_cyc;
    max_cyc = (low_cyc > high_cyc) ? low_cyc : high_cyc;
    return (max_cyc > 1) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/ft245_rx_if.sv
// FT245 read-side bus plus the single-entry valid/ready output stream.
interface ft245_rx_if;
  import ft245_pkg::*;

  logic              rxf_n;
  logic [DATA_W-1:0] data;
  logic              rd_n;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    input  rxf_n, data, rx_ready,
    output rd_n, rx_data, rx_valid
  );

  modport slave (
    output rxf_n, data, rx_ready,
    input  rd_n, rx_data, rx_valid
  );

endinterface

// File: rtl/ft245_rx_sync2.sv
// Two-flop synchroniser for the asynchronous RXF# line; resets to inactive (1).
module ft245_rx_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ft245_rx.sv
// FT245 read engine: strobes RD#, captures the byte, offers it on valid/ready.
// Optional FT245_RX_LED_EN adds a 4-bit LED view of captured bytes.
module ft245_rx
  import ft245_pkg::*;
#(
  parameter int unsigned RD_LOW_CYCLES  = RD_LOW_CYCLES_DEF,
  parameter int unsigned RD_HIGH_CYCLES = RD_HIGH_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  ft245_rx_if.master       bus,
  output logic [CNT_W-1:0] byte_count,
  output logic             busy
`ifdef FT245_RX_LED_EN
  ,
  output logic [3:0]       led
`endif
);

  localparam int unsigned     TMR_W     = timer_width(RD_LOW_CYCLES, RD_HIGH_CYCLES);
  localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(RD_LOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(RD_HIGH_CYCLES - 1);

  logic rxf_s;

  state_e            state_q,    state_d;
  logic [TMR_W-1:0]  timer_q,    timer_d;
  logic              rd_n_q,     rd_n_d;
  logic [DATA_W-1:0] rx_data_q,  rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              busy_q,     busy_d;
  logic              capture_c;
  logic              transfer_c;
`ifdef FT245_RX_LED_EN
  logic [3:0]        led_q,      led_d;
`endif

  ft245_rx_sync2 u_rxf_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.rxf_n),
    .q_o   (rxf_s)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rd_n_d     = rd_n_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    capture_c  = 1'b0;
    transfer_c = rx_valid_q && bus.rx_ready;

    unique case (state_q)
      IDLE: begin
        rd_n_d = 1'b1;
        // Only start a read when the output slot is free or draining this cycle.
        if (!rxf_s && (!rx_valid_q || bus.rx_ready)) begin
          rd_n_d  = 1'b0;
          timer_d = LOW_LOAD;
          state_d = STROBE;
        end
      end
      STROBE: begin
        rd_n_d = 1'b0;
        if (timer_q != '0) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          capture_c = 1'b1;
          rx_data_d = bus.data;
          cnt_d     = cnt_q + CNT_W'(1);
          rd_n_d    = 1'b1;
          timer_d   = HIGH_LOAD;
          state_d   = RECOVER;
        end
      end
      RECOVER: begin
        rd_n_d = 1'b1;
        if (timer_q != '0) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        rd_n_d  = 1'b1;
        timer_d = '0;
        state_d = IDLE;
      end
    endcase

    rx_valid_d = capture_c || (rx_valid_q && !transfer_c);
    busy_d     = (state_d != IDLE);

`ifdef FT245_RX_LED_EN
    led_d = led_q;
    if (capture_c) begin
      led_d = (cnt_d == '0) ? 4'hF : bus.data[3:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      rd_n_q     <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
`ifdef FT245_RX_LED_EN
      led_q      <= 4'h0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rd_n_q     <= rd_n_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
`ifdef FT245_RX_LED_EN
      led_q      <= led_d;
`endif
    end
  end

  assign bus.rd_n     = rd_n_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign byte_count   = cnt_q;
  assign busy         = busy_q;
`ifdef FT245_RX_LED_EN
  assign led          = led_q;
`endif

endmodule

// File: doc/ft245_rx.md
Name: ft245_rx

Overview:
- Read-side engine for the FT245-style asynchronous USB FIFO on the shared 8-bit `data` bus; it pulls bytes that the host has sent.
- It watches RXF#, strobes RD#, captures the byte and presents it on a single-entry valid/ready output stream to downstream logic.
- It is the counterpart of the bus-driving test logic: that logic drives the bus, this block samples it.
- It also counts received bytes for bring-up with LEDs and a scope.

Parameters:
- RD_LOW_CYCLES, 4, clk cycles RD# is held low; the byte is captured on the last of these (≥3 at 50 MHz for 50 ns data-valid).
- RD_HIGH_CYCLES, 4, clk cycles RD# is held high after a read before RXF# is sampled again; must be ≥3 (2-flop sync + 1).
- CNT_W, 16, width of byte_count.

Ports:
- clk  input  1  50 MHz system clock.
- reset  input  1  Synchronous, active-low reset.
- rxf_n  input  1  FT245 RXF#; asynchronous; low means a byte is available.
- data  input  8  FT245 data bus; valid while RD# is low.
- rd_n  output  1  FT245 RD#; low-pulse reads one byte.
- rx_data  output  8  Captured byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  Downstream accepts; a transfer happens when rx_valid && rx_ready at posedge clk.
- byte_count  output  CNT_W  Bytes captured since reset; wraps.
- busy  output  1  High in any state other than IDLE.

Behaviour:
- Reset (reset==0 at posedge clk), applied next edge:
  - rd_n=1, rx_data=8'h00, rx_valid=0, byte_count=0, state=IDLE, timer=0, sync flops=1 (inactive).
- RXF# synchronisation: rxf_n passes through a 2-flop synchroniser to give rxf_s. The data bus is not synchronised; by protocol it is stable while rd_n=0.
- IDLE:
  - If rxf_s==0 and (rx_valid==0 or rx_ready==1): rd_n<=0, timer<=RD_LOW_CYCLES-1, go STROBE.
  - Otherwise stay; rd_n=1.
- STROBE:
  - rd_n stays 0. While timer≠0, decrement.
  - When timer==0: rx_data<=data, rx_valid<=1, byte_count<=byte_count+1 (mod 2^CNT_W), rd_n<=1, timer<=RD_HIGH_CYCLES-1, go RECOVER.
- RECOVER:
  - rd_n=1. Decrement the timer; at 0 go IDLE.
  - rxf_s is ignored in this state (FT245 RXF# deassert delay).
- Output handshake:
  - rx_valid clears on a transfer unless a capture occurs in the same cycle; a capture wins and rx_valid stays 1.
  - rx_data is stable while rx_valid=1 and not accepted.
  - A capture cannot overwrite an unaccepted byte, because a read only starts when the slot is empty or is being emptied that cycle.
- Latency:
  - rd_n falls 1 clk after rxf_s is seen low in IDLE (3 clks after rxf_n falls, synchroniser included).
  - rx_valid rises RD_LOW_CYCLES clks after rd_n falls.
  - Minimum period per byte is RD_LOW_CYCLES+RD_HIGH_CYCLES+1 clks (9 at default).
- Backpressure: with rx_ready held 0 and rx_valid=1, the block stays in IDLE and rd_n stays 1. No byte is lost; the FT245 buffers.
- RXF# rising during STROBE: the read completes normally (the chip has committed the byte).
- Reset mid-STROBE: rd_n returns high on that edge. The FT245 pops that byte, and it is discarded; this loss is accepted behaviour.
- busy = (state≠IDLE).

Optional Feature:
- Macro FT245_RX_LED_EN.
- Defined:
  - Adds port `led` (output, 4 bits).
  - led<=rx_data's captured value [3:0] on each capture; reset value 4'b0000.
  - When byte_count wraps to 0, led is forced to 4'b1111 for that capture only.
- Undefined: no `led` port and no related logic; all other behaviour is identical.

Decomposition:
- Package ft245_pkg:
  - State encodings IDLE/STROBE/RECOVER.
  - FT245 default timing constants (RD_LOW_CYCLES=4, RD_HIGH_CYCLES=4).
  - CNT_W default.
- Sub-module sync2: 2-flop synchroniser for rxf_n, reset value 1. It is the only natural split.

Test Plan:
- Reset: reset=0 for 3 clks with rxf_n=0 → rd_n=1, rx_valid=0, byte_count=0, busy=0 throughout.
- Single byte:
  - Stimulus: rxf_n=0, data=8'hA5 during RD# low, rx_ready=1.
  - Response: rd_n low for exactly 4 clks; rx_data=8'hA5, rx_valid=1 for 1 clk; byte_count=1.
- Burst:
  - Stimulus: rxf_n held 0, 5 bytes 8'h01..8'h05, rx_ready=1.
  - Response: 5 RD# pulses, 9 clks apart; output order 01..05; byte_count=5.
- Backpressure:
  - Stimulus: rx_ready=0 after the first byte 8'h3C.
  - Response: rx_data=8'h3C held, no further rd_n pulse for 50 clks. Raising rx_ready releases the next read (rd_n falls on that edge+1).
- Reset mid-STROBE: reset=0 on the 2nd STROBE clk → rd_n=1 next edge, rx_valid=0, byte_count=0, state IDLE.
- Wrap/LED (FT245_RX_LED_EN, CNT_W=4):
  - 16 bytes → byte_count returns to 0, and led=4'b1111 on the 16th capture.
  - 17th byte 8'h09 → led=4'b1001.
